// File: rtl/jtdsp16_do_loop.sv
// ---------------------------------------------------------------------------
// jtdsp16_do_loop
//
// Zero-overhead "do" loop controller with a 15-word instruction cache.
//
// A do instruction (NI != 0) streams the loop body from ROM once. Each word
// the decoder accepts is captured into the cache as it goes by. Every later
// pass is replayed from the cache with the program counter held still.
// A redo instruction (NI == 0) replays the body already held in the cache.
// Loops never nest: a do/redo that arrives while a loop runs is dropped.
//
// Optional feature macro:
//   JTDSP16_REDO_EN  defined   -> redo (NI == 0) replays a valid cache
//                    undefined -> NI == 0 is always ignored and the
//                                 cache-valid tracking is not built
//
// Ports
//   rst         in   async active-high reset
//   clk         in   clock
//   cen         in   clock enable; state only moves when cen = 1
//   do_start    in   one-cycle pulse: do/redo instruction issued
//   do_data     in   [10:7] NI body length (0 = redo), [6:0] K pass count
//   inst_en     in   decoder accepts one instruction word this cycle
//   rom_dout    in   instruction word fetched from ROM
//   cache_dout  out  cache word at the current index (0 unless replaying)
//   up_xcache   out  instruction source is the cache, not ROM
//   pc_hold     out  program counter must not advance
//   irq_mask    out  interrupts blocked while a loop is active
//   loop_cnt    out  passes remaining including the current one (0 idle)
//   busy        out  a loop is active
// ---------------------------------------------------------------------------
module jtdsp16_do_loop (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        do_start,
  input  logic [10:0] do_data,
  input  logic        inst_en,
  input  logic [15:0] rom_dout,
  output logic [15:0] cache_dout,
  output logic        up_xcache,
  output logic        pc_hold,
  output logic        irq_mask,
  output logic [6:0]  loop_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam int CACHE_DEPTH = 15;

  state_t      state_q, state_d;
  logic [3:0]  idx_q,   idx_d;
  logic [3:0]  ni_q,    ni_d;
  logic [6:0]  rem_q,   rem_d;
`ifdef JTDSP16_REDO_EN
  logic        cache_valid_q, cache_valid_d;
`endif

  // Loop body storage. Deliberately not reset: it is only read while
  // replaying, and replay is only reachable after a complete fill.
  logic [15:0] cache_mem [0:CACHE_DEPTH-1];

  // Qualified events: nothing happens on a cycle without cen.
  logic        do_fire;
  logic        step;
  logic [3:0]  req_ni;
  logic [6:0]  req_passes;
  logic        last_word;
  logic        cache_we;

  assign do_fire    = cen & do_start;
  assign step       = cen & inst_en;
  assign req_ni     = do_data[10:7];
  // K = 0 is treated as a single pass.
  assign req_passes = (do_data[6:0] == 7'd0) ? 7'd1 : do_data[6:0];
  // Word at idx is the final one of the body.
  assign last_word  = (idx_q == (ni_q - 4'd1));
  assign cache_we   = (state_q == ST_FILL) & step;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ni_d    = ni_q;
    rem_d   = rem_q;
`ifdef JTDSP16_REDO_EN
    cache_valid_d = cache_valid_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // inst_en is ignored here; a simultaneous do_start wins.
        if (do_fire) begin
          if (req_ni != 4'd0) begin
            ni_d    = req_ni;
            rem_d   = req_passes;
            idx_d   = 4'd0;
            state_d = ST_FILL;
`ifdef JTDSP16_REDO_EN
            // Cache is being overwritten; it is unusable until fill ends.
            cache_valid_d = 1'b0;
`endif
          end
`ifdef JTDSP16_REDO_EN
          else if (cache_valid_q) begin
            // Redo: replay the stored body, ni is kept from the last do.
            rem_d   = req_passes;
            idx_d   = 4'd0;
            state_d = ST_REPEAT;
          end
`endif
        end
      end

      ST_FILL: begin
        if (step) begin
          if (last_word) begin
`ifdef JTDSP16_REDO_EN
            cache_valid_d = 1'b1;
`endif
            idx_d = 4'd0;
            if (rem_q == 7'd1) begin
              rem_d   = 7'd0;
              state_d = ST_IDLE;
            end else begin
              rem_d   = rem_q - 7'd1;
              state_d = ST_REPEAT;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      ST_REPEAT: begin
        if (step) begin
          if (last_word) begin
            idx_d = 4'd0;
            if (rem_q == 7'd1) begin
              rem_d   = 7'd0;
              state_d = ST_IDLE;
            end else begin
              rem_d = rem_q - 7'd1;
            end
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = 4'd0;
        rem_d   = 7'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      ni_q    <= 4'd0;
      rem_q   <= 7'd0;
`ifdef JTDSP16_REDO_EN
      cache_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ni_q    <= ni_d;
      rem_q   <= rem_d;
`ifdef JTDSP16_REDO_EN
      cache_valid_q <= cache_valid_d;
`endif
    end
  end

  // Capture ROM words as they pass during the first (fill) pass.
  always_ff @(posedge clk) begin
    if (cache_we) begin
      cache_mem[idx_q] <= rom_dout;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: all decoded from registers so an asynchronous reset clears
  // them in the same cycle.
  // -------------------------------------------------------------------------
  assign busy       = (state_q != ST_IDLE);
  assign irq_mask   = busy;
  assign up_xcache  = (state_q == ST_REPEAT);
  // PC is held for the whole replay and released on the edge that ends it.
  assign pc_hold    = (state_q == ST_REPEAT);
  assign loop_cnt   = busy ? rem_q : 7'd0;
  // Combinational read; idx stays below ni (<= 15) so it is always in range
  // while replaying.
  assign cache_dout = (state_q == ST_REPEAT) ? cache_mem[idx_q] : 16'd0;

endmodule

// File: tb/tb_jtdsp16_do_loop.sv
module tb_jtdsp16_do_loop;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        do_start;
  logic [10:0] do_data;
  logic        inst_en;
  logic [15:0] rom_dout;
  logic [15:0] cache_dout;
  logic        up_xcache;
  logic        pc_hold;
  logic        irq_mask;
  logic [6:0]  loop_cnt;
  logic        busy;

  jtdsp16_do_loop dut (
    .rst        (rst),
    .clk        (clk),
    .cen        (cen),
    .do_start   (do_start),
    .do_data    (do_data),
    .inst_en    (inst_en),
    .rom_dout   (rom_dout),
    .cache_dout (cache_dout),
    .up_xcache  (up_xcache),
    .pc_hold    (pc_hold),
    .irq_mask   (irq_mask),
    .loop_cnt   (loop_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

`ifdef JTDSP16_REDO_EN
  localparam bit REDO = 1'b1;
`else
  localparam bit REDO = 1'b0;
`endif

  localparam logic [15:0] WA = 16'hA00A;
  localparam logic [15:0] WB = 16'hB00B;
  localparam logic [15:0] WC = 16'hC00C;
  localparam logic [15:0] WJ = 16'h1234;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A loop is a run of m_total accepted words; word number m_pos belongs to
  // pass m_pos / m_n at body offset m_pos % m_n. Pass 0 of a do comes from
  // ROM, every other pass (and every pass of a redo) from the cache.
  int          m_n, m_kk, m_pos, m_total;
  bit          m_fill, m_valid;
  logic [15:0] m_body [15];

  function automatic bit m_busy();
    return m_pos < m_total;
  endfunction

  function automatic int m_pass();
    return (m_n == 0) ? 0 : m_pos / m_n;
  endfunction

  function automatic bit m_replay();
    return m_busy() && (!m_fill || m_pass() > 0);
  endfunction

  task automatic model_reset();
    m_pos = 0; m_total = 0; m_valid = 0; m_n = 0; m_kk = 0; m_fill = 0;
  endtask

  task automatic model_edge();
    int ni, k;
    if (!cen) return;
    if (m_busy()) begin
      if (inst_en) begin
        if (m_fill && m_pass() == 0) m_body[m_pos % m_n] = rom_dout;
        m_pos++;
        if (m_fill && m_pos == m_n) m_valid = 1;
      end
    end else if (do_start) begin
      ni = int'(do_data[10:7]);
      k  = int'(do_data[6:0]);
      if (k == 0) k = 1;
      if (ni != 0) begin
        m_n = ni; m_kk = k; m_pos = 0; m_total = ni * k; m_fill = 1; m_valid = 0;
      end else if (REDO && m_valid) begin
        m_kk = k; m_pos = 0; m_total = m_n * k; m_fill = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    bit          eb, er;
    logic [6:0]  ec;
    logic [15:0] ed;
    eb = m_busy();
    er = m_replay();
    ec = eb ? 7'(m_kk - m_pass()) : 7'd0;
    ed = er ? m_body[m_pos % m_n] : 16'd0;
    chk($sformatf("%s_busy", tag), busy, eb);
    chk($sformatf("%s_irq", tag), irq_mask, eb);
    chk($sformatf("%s_xcache", tag), up_xcache, er);
    chk($sformatf("%s_pchold", tag), pc_hold, er);
    chk($sformatf("%s_cnt", tag), loop_cnt, ec);
    chk($sformatf("%s_dout", tag), cache_dout, ed);
  endtask

  // One clock: drive, edge, update model, sample 1 time unit later.
  task automatic cycle(input logic c, input logic ds, input logic [10:0] dd,
                       input logic ie, input logic [15:0] rom, input string tag);
    cen = c; do_start = ds; do_data = dd; inst_en = ie; rom_dout = rom;
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk($sformatf("%s_busy", tag), busy, 0);
    chk($sformatf("%s_irq", tag), irq_mask, 0);
    chk($sformatf("%s_xcache", tag), up_xcache, 0);
    chk($sformatf("%s_pchold", tag), pc_hold, 0);
    chk($sformatf("%s_cnt", tag), loop_cnt, 0);
    chk($sformatf("%s_dout", tag), cache_dout, 0);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #1 rst = 1'b1;
    #1 check_all_zero(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        cen;
    logic        ds;
    logic [10:0] dd;
    logic        ie;
    logic [15:0] rom;
    logic        busy;
    logic        up;
    logic [6:0]  cnt;
    logic [15:0] dout;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic ds, input logic [10:0] dd,
                              input logic ie, input logic [15:0] rom, input logic b,
                              input logic up, input logic [6:0] cnt, input logic [15:0] dout);
    vec_t v;
    v.cen = c; v.ds = ds; v.dd = dd; v.ie = ie; v.rom = rom;
    v.busy = b; v.up = up; v.cnt = cnt; v.dout = dout;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    logic [15:0] redo_words [6];
    bit          seen_up;

    // do NI=3 K=4, body A,B,C; then replays with a stray do_start and a
    // frozen (cen=0) cycle in the middle.
    tbl.push_back(mk(1, 1, {4'd3, 7'd4}, 1, WJ, 1, 0, 7'd4, 16'd0));
    tbl.push_back(mk(1, 0, 11'd0, 1, WA, 1, 0, 7'd4, 16'd0));
    tbl.push_back(mk(1, 0, 11'd0, 1, WB, 1, 0, 7'd4, 16'd0));
    tbl.push_back(mk(1, 0, 11'd0, 1, WC, 1, 1, 7'd3, WA));
    tbl.push_back(mk(1, 0, 11'd0, 1, WJ, 1, 1, 7'd3, WB));
    tbl.push_back(mk(0, 0, 11'd0, 1, WJ, 1, 1, 7'd3, WB));
    tbl.push_back(mk(1, 0, 11'd0, 1, WJ, 1, 1, 7'd3, WC));
    tbl.push_back(mk(1, 0, 11'd0, 1, WJ, 1, 1, 7'd2, WA));
    tbl.push_back(mk(1, 1, {4'd5, 7'd9}, 0, WJ, 1, 1, 7'd2, WA));
    tbl.push_back(mk(1, 0, 11'd0, 1, WJ, 1, 1, 7'd2, WB));
    tbl.push_back(mk(1, 0, 11'd0, 1, WJ, 1, 1, 7'd2, WC));
    tbl.push_back(mk(1, 0, 11'd0, 1, WJ, 1, 1, 7'd1, WA));
    tbl.push_back(mk(1, 0, 11'd0, 1, WJ, 1, 1, 7'd1, WB));
    tbl.push_back(mk(1, 0, 11'd0, 1, WJ, 1, 1, 7'd1, WC));
    tbl.push_back(mk(1, 0, 11'd0, 1, WJ, 0, 0, 7'd0, 16'd0));
    tbl.push_back(mk(1, 0, 11'd0, 1, WJ, 0, 0, 7'd0, 16'd0));

    redo_words = '{WA, WB, WC, WA, WB, WC};
    for (int i = 0; i < 15; i++) m_body[i] = 16'd0;

    // ---- reset state ----
    rst = 1'b1; cen = 1'b0; do_start = 1'b0; do_data = '0; inst_en = 1'b0; rom_dout = '0;
    model_reset();
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // ---- table ----
    foreach (tbl[i]) begin
      cycle(tbl[i].cen, tbl[i].ds, tbl[i].dd, tbl[i].ie, tbl[i].rom, "tblm");
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_xcache", i), up_xcache, tbl[i].up);
      chk($sformatf("tbl%0d_cnt", i), loop_cnt, tbl[i].cnt);
      chk($sformatf("tbl%0d_dout", i), cache_dout, tbl[i].dout);
      $display("vec %0d: busy=%0b xcache=%0b cnt=%0d dout=%h", i, busy, up_xcache, loop_cnt, cache_dout);
    end

    // ---- redo K=2 after the loop above ----
    cycle(1, 1, {4'd0, 7'd2}, 0, WJ, "redo");
    chk("redo_start_busy", busy, REDO);
    for (int i = 0; i < 6; i++) begin
      if (REDO) chk($sformatf("redo_word%0d", i), cache_dout, redo_words[i]);
      cycle(1, 0, 11'd0, 1, WJ, "redo");
    end
    chk("redo_end_busy", busy, 0);
    $display("redo: done busy=%0b", busy);

    // ---- reset mid-REPEAT, then redo must be ignored ----
    cycle(1, 1, {4'd3, 7'd4}, 0, WJ, "rst_do");
    for (int i = 0; i < 5; i++) cycle(1, 0, 11'd0, 1, 16'(16'h5000 + i), "rst_do");
    chk("rst_pre_xcache", up_xcache, 1);
    async_reset("rst_mid");
    cycle(1, 1, {4'd0, 7'd2}, 0, WJ, "rst_redo");
    chk("rst_redo_busy", busy, 0);
    $display("reset mid-repeat: redo busy=%0b", busy);

    // ---- NI=2 K=1: fill only ----
    seen_up = 1'b0;
    cycle(1, 1, {4'd2, 7'd1}, 0, WJ, "k1");
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 11'd0, 1, 16'(16'h7700 + i), "k1");
      if (up_xcache) seen_up = 1'b1;
    end
    chk("k1_never_xcache", seen_up, 0);
    chk("k1_idle", busy, 0);
    cycle(1, 1, {4'd0, 7'd1}, 0, WJ, "k1_redo");
    chk("k1_redo_busy", busy, REDO);
    cycle(1, 0, 11'd0, 1, WJ, "k1_redo");
    cycle(1, 0, 11'd0, 1, WJ, "k1_redo");
    chk("k1_redo_done", busy, 0);
    $display("ni2 k1: xcache_seen=%0b", seen_up);

    // ---- K=0 behaves as K=1 ----
    cycle(1, 1, {4'd2, 7'd0}, 0, WJ, "k0");
    chk("k0_cnt", loop_cnt, 1);
    cycle(1, 0, 11'd0, 1, WJ, "k0");
    cycle(1, 0, 11'd0, 1, WJ, "k0");
    chk("k0_idle", busy, 0);

    // ---- NI=15 K=127 ----
    cycle(1, 1, {4'd15, 7'd127}, 0, WJ, "big");
    for (int i = 0; i < 15 * 127; i++) cycle(1, 0, 11'd0, 1, 16'($urandom), "big");
    chk("big_irq_after", irq_mask, 0);
    $display("ni15 k127: irq_mask=%0b after last word", irq_mask);

    // ---- inst_en held, cen toggling ----
    cycle(1, 1, {4'd4, 7'd2}, 0, WJ, "cen");
    for (int i = 0; i < 16; i++) cycle(logic'(i % 2 == 0), 0, 11'd0, 1, 16'(16'h3300 + i), "cen");
    chk("cen_done", busy, 0);
    $display("cen toggle: busy=%0b", busy);

    // ---- randomized ----
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] ni;
      logic [6:0] k;
      ni = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      k  = 7'($urandom_range(0, 6));
      cycle(logic'($urandom_range(0, 4) != 0), logic'($urandom_range(0, 19) == 0),
            {ni, k}, logic'($urandom_range(0, 9) < 6), 16'($urandom), "rnd");
      if ($urandom_range(0, 399) == 0) async_reset("rnd_rst");
    end
    $display("random: complete");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtdsp16_do_loop.md
JTDSP16_DO_LOOP -- requirements
Module: jtdsp16_do_loop

Interface
REQ-001 SHALL have: rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have: clk  in  1  clock.
REQ-003 SHALL have: cen  in  1  clock enable; all state changes only when cen=1.
REQ-004 SHALL have: do_start  in  1  one-cycle pulse from decoder, do/redo instruction issued.
REQ-005 SHALL have: do_data  in  11  [10:7]=NI (body length, 0 means redo), [6:0]=K (pass count).
REQ-006 SHALL have: inst_en  in  1  pulse, decoder accepts one instruction word this cycle.
REQ-007 SHALL have: rom_dout  in  16  instruction word fetched from ROM.
REQ-008 SHALL have: cache_dout  out  16  cache word at current index, combinational read.
REQ-009 SHALL have: up_xcache  out  1  instruction source is cache, not ROM.
REQ-010 SHALL have: pc_hold  out  1  PC must not advance.
REQ-011 SHALL have: irq_mask  out  1  interrupts blocked while a loop is active.
REQ-012 SHALL have: loop_cnt  out  7  passes remaining including current pass.
REQ-013 SHALL have: busy  out  1  state not IDLE.

Function
REQ-014 SHALL implement states IDLE, FILL, REPEAT; 15x16-bit cache, 4-bit index idx, 4-bit stored length ni, 7-bit pass counter rem, cache_valid flag.
REQ-015 IDLE + do_start + NI!=0: latch ni=NI, rem=max(K,1), idx=0, clear cache_valid, go FILL on the same cen edge.
REQ-016 FILL: each inst_en writes rom_dout to cache[idx], idx++; up_xcache=0, pc_hold=0.
REQ-017 FILL, inst_en with idx==ni-1: set cache_valid; rem==1 -> IDLE; else rem--, idx=0, go REPEAT.
REQ-018 REPEAT: up_xcache=1, pc_hold=1, cache_dout=cache[idx]; each inst_en idx++.
REQ-019 REPEAT, inst_en with idx==ni-1: rem==1 -> IDLE, pc_hold drops same edge; else rem--, idx=0.
REQ-020 Redo (IDLE + do_start + NI==0): cache_valid=1 -> rem=max(K,1), idx=0, go REPEAT, ni unchanged; cache_valid=0 -> ignored, stay IDLE.
REQ-021 do_start while busy SHALL be ignored (no nesting); state, counters, cache untouched.
REQ-022 do_start and inst_en in same cycle in IDLE: do_start taken; inst_en does not write cache.
REQ-023 irq_mask=busy; loop_cnt=rem when busy, 0 in IDLE.
REQ-024 cen=0 SHALL freeze all state; inst_en/do_start ignored when cen=0.
REQ-025 K=0 SHALL behave as K=1 (single ROM pass, no cache replay).

Reset
REQ-026 rst SHALL force IDLE, idx=0, ni=0, rem=0, cache_valid=0; all outputs 0.
REQ-027 Cache array contents SHALL NOT be reset; reads gated by cache_valid/state only.
REQ-028 rst mid-loop SHALL abort immediately; the next redo is ignored until a new do completes FILL.

Configuration
REQ-029 Macro JTDSP16_REDO_EN defined: redo per REQ-020.
REQ-030 Macro JTDSP16_REDO_EN undefined: do_start with NI==0 always ignored; cache_valid logic may be removed.

Verification
REQ-031 do NI=3 K=4, body words A,B,C on inst_en -> FILL captures A,B,C; cache_dout A,B,C repeated 3 times, up_xcache=1, loop_cnt 3,2,1, then IDLE.
REQ-032 do NI=2 K=1 -> FILL only, returns to IDLE after 2nd inst_en, up_xcache never 1, cache_valid=1.
REQ-033 After REQ-031, redo K=2 -> REPEAT two passes A,B,C,A,B,C, no ROM capture; after reset, redo K=2 -> ignored, busy=0.
REQ-034 do NI=15 K=127 -> idx wraps 14->0 each pass, 126 replays, irq_mask=1 throughout, 0 after last inst_en.
REQ-035 do_start pulse during REPEAT -> ignored, loop_cnt sequence unchanged; rst asserted mid-REPEAT -> all outputs 0 same cycle.
REQ-036 inst_en held with cen toggling 1/0 -> idx advances only on cen=1 edges.
